// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache between the CPU fetch stage and a
// block-read instruction memory (16-byte lines).
//
// Ports:
//   clock        system clock, all state updates on posedge
//   reset        asynchronous, active-low
//   read         CPU fetch request
//   address      CPU byte address ([1:0] ignored)
//   instruction  fetched word, valid while read=1 and busywait=0
//   busywait     CPU stall request
//   mem_read     line-read request to instruction memory
//   mem_address  block address of the line being fetched
//   mem_readinst 128-bit line from memory, byte 0 in [7:0]
//   mem_busywait memory busy; refill data valid when it falls
module instruction_cache #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned INDEX_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [31:0]           instruction,
    output logic                  busywait,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-5:0] mem_address,
    input  logic [127:0]          mem_readinst,
    input  logic                  mem_busywait
);

    localparam int unsigned TagWidth = ADDR_WIDTH - 4 - INDEX_WIDTH;
    localparam int unsigned Lines    = 2 ** INDEX_WIDTH;

    typedef enum logic [1:0] {StIdle, StMemRead, StUpdate} state_e;

    state_e                 state_q, state_d;
    logic [Lines-1:0]       valid_q, valid_d;
    logic [TagWidth-1:0]    lat_tag_q, lat_tag_d;
    logic [INDEX_WIDTH-1:0] lat_index_q, lat_index_d;
    logic [127:0]           line_q, line_d;
    logic [31:0]            instr_q, instr_d;

    // Tag/data storage is not reset; valid bits alone qualify it.
    logic [TagWidth-1:0]    tag_array_q  [Lines];
    logic [127:0]           data_array_q [Lines];

    logic [TagWidth-1:0]    addr_tag;
    logic [INDEX_WIDTH-1:0] addr_index;
    logic [1:0]             addr_offset;
    logic                   hit;
    logic [31:0]            hit_word;
    logic                   unused_addr;

    assign addr_tag    = address[ADDR_WIDTH-1:4+INDEX_WIDTH];
    assign addr_index  = address[4+INDEX_WIDTH-1:4];
    assign addr_offset = address[3:2];
    assign unused_addr = ^address[1:0];

    assign hit = read && valid_q[addr_index] && (tag_array_q[addr_index] == addr_tag);
    assign hit_word = data_array_q[addr_index][{addr_offset, 5'b00000} +: 32];

    assign mem_address = {lat_tag_q, lat_index_q};

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        lat_tag_d   = lat_tag_q;
        lat_index_d = lat_index_q;
        line_d      = line_q;
        instr_d     = instr_q;
        instruction = instr_q;
        busywait    = 1'b0;
        mem_read    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (read) begin
                    if (hit) begin
                        instruction = hit_word;
                        instr_d     = hit_word;
                    end else begin
                        busywait    = 1'b1;
                        lat_tag_d   = addr_tag;
                        lat_index_d = addr_index;
                        state_d     = StMemRead;
                    end
                end
            end
            StMemRead: begin
                mem_read = 1'b1;
                busywait = 1'b1;
                // Only sampled after a full cycle in this state, so a memory that
                // raises busywait a delta after mem_read is never mistaken for done.
                if (!mem_busywait) begin
                    line_d  = mem_readinst;
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                busywait             = 1'b1;
                valid_d[lat_index_q] = 1'b1;
                state_d              = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // While held in reset the CPU must not be stalled even if read is high.
        if (!reset) begin
            busywait = 1'b0;
            mem_read = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            lat_tag_q   <= '0;
            lat_index_q <= '0;
            line_q      <= '0;
            instr_q     <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            lat_tag_q   <= lat_tag_d;
            lat_index_q <= lat_index_d;
            line_q      <= line_d;
            instr_q     <= instr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == StUpdate) begin
            data_array_q[lat_index_q] <= line_q;
            tag_array_q[lat_index_q]  <= lat_tag_q;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed fetch sequence against a
// simple block-read memory model with a fixed busy latency.
module tb_instruction_cache;

    logic         clock;
    logic         reset;
    logic         read;
    logic [9:0]   address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readinst;
    logic         mem_busywait;

    int n_checks = 0;
    int n_fails  = 0;
    int mem_reads = 0;
    int mem_lat   = 3;

    instruction_cache #(
        .ADDR_WIDTH  (10),
        .INDEX_WIDTH (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readinst (mem_readinst),
        .mem_busywait (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory contents: blocks 0 and 1 carry the reference words, others are
    // {16'hC000, 2'b00, block, word index}.
    function automatic logic [127:0] mem_line(input logic [5:0] blk);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) begin
            l[32*k +: 32] = {16'hC000, 2'b00, blk, 8'(k)};
        end
        if (blk == 6'd0) l = {32'h0001005A, 32'h02060405, 32'h0005000A, 32'h0004001B};
        if (blk == 6'd1) l[31:0] = 32'h00040003;
        return l;
    endfunction

    // Memory model: raises busywait a delta after mem_read, drops it with the
    // line after mem_lat clocks.
    initial begin
        logic [5:0] blk;
        mem_busywait = 1'b0;
        mem_readinst = '0;
        forever begin
            wait (mem_read === 1'b1);
            mem_busywait = 1'b1;
            mem_reads++;
            blk = mem_address;
            repeat (mem_lat) @(posedge clock);
            #1;
            mem_readinst = mem_line(blk);
            mem_busywait = 1'b0;
            @(posedge clock);
            #1;
        end
    end

    task automatic fetch(input string tag, input logic [9:0] addr, input bit exp_miss,
                         input logic [5:0] exp_blk, input logic [31:0] exp_word);
        int cyc;
        int reads0;
        logic [5:0] blk_seen;
        blk_seen = 'x;
        @(negedge clock);
        read    = 1'b1;
        address = addr;
        #1;
        reads0 = mem_reads;
        check_eq({tag, " busy"}, 32'(busywait), 32'(exp_miss));
        check_eq({tag, " mr0"}, 32'(mem_read), 32'd0);
        cyc = 0;
        while (busywait && cyc < 100) begin
            @(negedge clock);
            #1;
            if (mem_read) blk_seen = mem_address;
            cyc++;
        end
        check_eq({tag, " stall_bound"}, 32'(cyc < 100), 32'd1);
        if (exp_miss) check_eq({tag, " maddr"}, 32'(blk_seen), 32'(exp_blk));
        check_eq({tag, " nreads"}, 32'(mem_reads - reads0), exp_miss ? 32'd1 : 32'd0);
        check_eq({tag, " instr"}, instruction, exp_word);
    endtask

    initial begin
        int cyc;
        reset   = 1'b0;
        read    = 1'b0;
        address = '0;
        #13;
        check_eq("rst busy", 32'(busywait), 32'd0);
        check_eq("rst mr", 32'(mem_read), 32'd0);
        check_eq("rst maddr", 32'(mem_address), 32'd0);
        check_eq("rst instr", instruction, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Cold miss, then hits within the same line.
        fetch("t1 a0", 10'h000, 1'b1, 6'h00, 32'h0004001B);
        fetch("t2 a4", 10'h004, 1'b0, 6'h00, 32'h0005000A);
        fetch("t2 a8", 10'h008, 1'b0, 6'h00, 32'h02060405);
        fetch("t2 aC", 10'h00C, 1'b0, 6'h00, 32'h0001005A);
        // Second line, first stays resident.
        fetch("t3 a10", 10'h010, 1'b1, 6'h01, 32'h00040003);
        fetch("t3 a0", 10'h000, 1'b0, 6'h00, 32'h0004001B);
        // Conflict on index 0.
        fetch("t4 a80", 10'h080, 1'b1, 6'h08, 32'hC0000800);
        fetch("t4 a84", 10'h084, 1'b0, 6'h08, 32'hC0000801);
        fetch("t4 a0", 10'h000, 1'b1, 6'h00, 32'h0004001B);
        fetch("t4 a84b", 10'h084, 1'b1, 6'h08, 32'hC0000801);
        // Highest line, offset 3.
        fetch("hi a3FC", 10'h3FC, 1'b1, 6'h3F, 32'hC0003F03);
        fetch("hi a3F0", 10'h3F0, 1'b0, 6'h3F, 32'hC0003F00);

        // Reset while the refill is in flight.
        @(negedge clock);
        read    = 1'b1;
        address = 10'h100;
        cyc = 0;
        while (!mem_read && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        check_eq("t5 mr_seen", 32'(mem_read), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("t5 mr", 32'(mem_read), 32'd0);
        check_eq("t5 busy", 32'(busywait), 32'd0);
        read = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (6) @(negedge clock);
        fetch("t5 a0", 10'h000, 1'b1, 6'h00, 32'h0004001B);

        // Idle with wandering address.
        @(negedge clock);
        read = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            address = 10'(i * 52 + 4);
            #1;
            check_eq("t6 busy", 32'(busywait), 32'd0);
            check_eq("t6 mr", 32'(mem_read), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
